rca_mult_seq_ctrl: RTL

- Sequential shift-add multiplier controller that time-shares one external rca_nbit instance (width M) to form an unsigned M x N product.
- Iterates one partial-product add per clock, then presents the product with a one-cycle done pulse.
- Serves as the low-area alternative to the combinational array multiplier built from rca_nbit rows.

---
 rtl/rca_mult_seq_ctrl.sv | 126 ++++++++++++
 1 files changed

// File: rtl/rca_mult_seq_ctrl.sv
// rca_mult_seq_ctrl: sequential shift-add multiplier controller.
// Time-shares one external M-bit ripple-carry adder to form an unsigned
// M x N product, one partial-product add per clock, N iterations.
// Optional build macro MULT_ZERO_BYPASS_EN: a zero operand on accept
// skips the RUN phase and completes in one cycle with product 0.
module rca_mult_seq_ctrl #(
  parameter int M = 4,
  parameter int N = 4
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           start,
  input  logic [M-1:0]   a,
  input  logic [N-1:0]   b,
  output logic           busy,
  output logic           done,
  output logic [M+N-1:0] product,
  output logic [M-1:0]   rca_a,
  output logic [M-1:0]   rca_b,
  output logic           rca_cin,
  input  logic [M-1:0]   rca_sum,
  input  logic           rca_cout
);

  localparam int CW = $clog2(N + 1);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t         state_q;
  logic [M-1:0]   mcand_q;
  logic [M-1:0]   acc_hi_q;
  logic [N-1:0]   acc_lo_q;
  logic [CW-1:0]  cnt_q;
  logic           busy_q;
  logic           done_q;
  logic [M+N-1:0] product_q;

  logic [M-1:0]   acc_hi_d;
  logic [N-1:0]   acc_lo_d;
  logic [M:0]     hi_full;
  logic [N:0]     lo_full;
  logic           last_iter;

  // The adder result plus carry becomes the upper half shifted right by one;
  // the bit shifted out of the sum enters the top of the multiplier half.
  assign hi_full   = {rca_cout, rca_sum};
  assign lo_full   = {rca_sum[0], acc_lo_q};
  assign acc_hi_d  = hi_full[M:1];
  assign acc_lo_d  = lo_full[N:1];
  assign last_iter = (cnt_q == CW'(N - 1));

  // Adder operands: running high half plus the multiplicand when the current
  // multiplier bit is set; both operands are quiet outside RUN.
  always_comb begin
    rca_a = '0;
    rca_b = '0;
    if (state_q == RUN) begin
      rca_a = acc_hi_q;
      rca_b = acc_lo_q[0] ? mcand_q : '0;
    end
  end

  assign rca_cin = 1'b0;
  assign busy    = busy_q;
  assign done    = done_q;
  assign product = product_q;

  // Control FSM with registered busy/done/product and the shift-add datapath.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      mcand_q   <= '0;
      acc_hi_q  <= '0;
      acc_lo_q  <= '0;
      cnt_q     <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      product_q <= '0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        IDLE, DONE: begin
          if (start) begin
            mcand_q  <= a;
            acc_hi_q <= '0;
            acc_lo_q <= b;
            cnt_q    <= '0;
`ifdef MULT_ZERO_BYPASS_EN
            if ((a == '0) || (b == '0)) begin
              product_q <= '0;
              done_q    <= 1'b1;
              busy_q    <= 1'b0;
              state_q   <= DONE;
            end else begin
              busy_q  <= 1'b1;
              state_q <= RUN;
            end
`else
            busy_q  <= 1'b1;
            state_q <= RUN;
`endif
          end else begin
            busy_q  <= 1'b0;
            state_q <= IDLE;
          end
        end
        RUN: begin
          acc_hi_q <= acc_hi_d;
          acc_lo_q <= acc_lo_d;
          cnt_q    <= cnt_q + 1'b1;
          if (last_iter) begin
            product_q <= {acc_hi_d, acc_lo_d};
            done_q    <= 1'b1;
            busy_q    <= 1'b0;
            state_q   <= DONE;
          end
        end
        default: begin
          busy_q  <= 1'b0;
          state_q <= IDLE;
        end
      endcase
    end
  end

endmodule
